serial_twos_comp_word: RTL and testbench
========================================

// Module: serial_twos_comp_word
// PURPOSE
//  Word-framed serial two's-complement engine, LSB-first bit-serial in and out.
//  Generalises the single-stream serial inverter: adds parametrised word length, framing,
//  per-word mode (pass / one's complement / negate / absolute value), overflow flagging and
//  frame-error recovery. Collects a full word before emitting, so the sign bit (MSB) is known.
//  Sits between the serial receiver and serial accumulator in the bit-serial datapath.
// PARAMETERS
//  WIDTH  8  bits per word (>=2); sets input/output bit counters and word buffer width
// PORTS
//  t_clk    in   1  clock, all state on rising edge
//  r        in   1  reset, asynchronous, active-low
//  i        in   1  serial data bit, LSB first
//  i_valid  in   1  i (and i_sof) sampled this cycle
//  i_sof    in   1  start of frame: marks bit 0 of a word; ignored when i_valid=0
//  mode     in   2  00 pass, 01 one's complement, 10 negate, 11 absolute value
//  y        out  1  serial result bit, LSB first
//  y_valid  out  1  y carries a result bit
//  y_sof    out  1  high with y_valid on result bit 0
//  ovf      out  1  high with y_valid on result bit WIDTH-1 when negating 100..0
//  err_frm  out  1  one-cycle pulse: word aborted by an early i_sof
// BEHAVIOUR
//  Reset (r=0, async): y, y_valid, y_sof, ovf, err_frm = 0; input FSM -> HUNT; counters,
//   word buffer and output shifter cleared; a word being output is abandoned, not resumed.
//  Input FSM, advances only on cycles with i_valid=1:
//   HUNT: i_sof=0 -> bit discarded; i_sof=1 -> store as bit 0, cnt_in=1, go COLLECT.
//   COLLECT: i_sof=0 -> store bit cnt_in, cnt_in++; i_sof=1 -> err_frm=1 next cycle,
//    partial word dropped, this bit stored as bit 0, cnt_in=1.
//   On the edge that stores bit WIDTH-1: full word + mode copied to output shifter,
//    cnt_in=0, FSM -> HUNT. mode is sampled on that edge only; changes mid-word ignored.
//   i_valid gaps allowed anywhere inside a word; partial word is held.
//  Output: starting the cycle after the load edge, y_valid=1 for exactly WIDTH consecutive
//   cycles, one bit per cycle, LSB first; y_sof=1 on the first. All outputs registered.
//   Latency: result bit 0 valid 1 cycle after the edge sampling input bit WIDTH-1.
//   Back-to-back input words (no gaps) give back-to-back output words with no overlap;
//   a load edge coinciding with the last output bit of the previous word is legal.
//  Transform per bit b (seen cleared at word load):
//   pass: y=b.  ones: y=~b.  negate: y = seen ? ~b : b; seen |= b.
//   abs: negate if word bit WIDTH-1 = 1, else pass.
//  ovf: negate or abs on word 1 followed by WIDTH-1 zeros, MSB first (most-negative value);
//   result wraps to the same value; ovf=1 only on bit WIDTH-1 cycle.
//  Negate of 0 -> 0, ovf=0.
//  err_frm never asserted from HUNT; it does not disturb a word currently being output.
// TESTING (WIDTH=8; words written hex, sent LSB first)
//  negate 0x05 (1,0,1,0,0,0,0,0) -> y 0xFB (1,1,0,1,1,1,1,1), y_sof on bit 0, ovf=0.
//  abs 0xFB -> 0x05; abs 0x05 -> 0x05; ones 0x3C -> 0xC3; pass 0xA5 -> 0xA5.
//  negate 0x80 -> 0x80 with ovf=1 on bit 7 only; negate 0x00 -> 0x00, ovf=0.
//  0x05 with i_valid low 3 cycles between bits 2 and 3 -> same 0xFB, output starts 1 cycle after bit 7.
//  i_sof again at bit 3 -> err_frm single pulse; new word 0x01 completes -> negate gives 0xFF.
//  Bits with i_sof=0 in HUNT -> no y_valid; r low mid-output -> outputs 0 at once, next word clean.

Source files
------------

// File: rtl/serial_twos_comp_word.sv
// serial_twos_comp_word: word-framed LSB-first serial two's-complement engine
// (pass / one's complement / negate / absolute value) with overflow flag and frame-error recovery.
// Latency: result bit 0 is valid 1 cycle after the edge that samples input bit WIDTH-1.
// Backpressure: none; input bits are accepted whenever i_valid=1 and output runs for exactly WIDTH cycles.
//
// Ports:
//   t_clk    clock, all state on rising edge
//   r        asynchronous active-low reset
//   i        serial data bit, LSB first
//   i_valid  i and i_sof are sampled this cycle
//   i_sof    start of frame, marks bit 0 of a word (ignored when i_valid=0)
//   mode     00 pass, 01 one's complement, 10 negate, 11 absolute value (sampled at word load)
//   y        serial result bit, LSB first
//   y_valid  y carries a result bit
//   y_sof    high with y_valid on result bit 0
//   ovf      high with y_valid on result bit WIDTH-1 when negating the most-negative value
//   err_frm  one-cycle pulse when a partial word is aborted by an early i_sof
module serial_twos_comp_word #(
   parameter int WIDTH = 8
) (
   input  logic       t_clk,
   input  logic       r,
   input  logic       i,
   input  logic       i_valid,
   input  logic       i_sof,
   input  logic [1:0] mode,
   output logic       y,
   output logic       y_valid,
   output logic       y_sof,
   output logic       ovf,
   output logic       err_frm
);

   localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   ONE      = CW'(1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {HUNT, COLLECT} in_state_t;

   in_state_t        state;
   logic [CW-1:0]    cnt_in;
   logic [WIDTH-1:0] word_buf;

   // Output side: shreg holds the bits still to be emitted, bit 0 next.
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    rem;
   logic             neg_r;
   logic             inv_r;
   logic             ovf_arm;
   logic             seen;

   logic             load;
   logic [WIDTH-1:0] word_full;
   logic             neg_ld;
   logic             inv_ld;
   logic             out_bit;

   // The last bit completes the word in the same cycle it is sampled, so the
   // shifter is loaded from the buffer with the live bit spliced in as the MSB.
   always_comb begin
      word_full            = word_buf;
      word_full[WIDTH-1]   = i;
   end

   assign load   = i_valid && (state == COLLECT) && !i_sof && (cnt_in == LAST);
   assign inv_ld = (mode == 2'b01);
   // abs becomes negate only when the completed word is negative
   assign neg_ld = (mode == 2'b10) || ((mode == 2'b11) && word_full[WIDTH-1]);

   // Negate: bits up to and including the first 1 pass, all later bits invert.
   assign out_bit = inv_r             ? ~shreg[0] :
                    (neg_r && seen)   ? ~shreg[0] :
                                         shreg[0];

   // Input framing FSM
   always_ff @(posedge t_clk or negedge r) begin
      if (!r) begin
         state    <= HUNT;
         cnt_in   <= '0;
         word_buf <= '0;
         err_frm  <= 1'b0;
      end else begin
         err_frm <= 1'b0;
         if (i_valid) begin
            case (state)
               HUNT: begin
                  if (i_sof) begin
                     word_buf <= {{(WIDTH-1){1'b0}}, i};
                     cnt_in   <= ONE;
                     state    <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (i_sof) begin
                     // early start of frame: drop the partial word, restart on this bit
                     err_frm  <= 1'b1;
                     word_buf <= {{(WIDTH-1){1'b0}}, i};
                     cnt_in   <= ONE;
                  end else if (cnt_in == LAST) begin
                     cnt_in <= '0;
                     state  <= HUNT;
                  end else begin
                     word_buf[cnt_in] <= i;
                     cnt_in           <= cnt_in + ONE;
                  end
               end
               default: begin
                  state  <= HUNT;
                  cnt_in <= '0;
               end
            endcase
         end
      end
   end

   // Output shifter. Bit 0 is produced directly on the load edge so the result
   // starts the very next cycle; a new load always overrides (it can only
   // coincide with the final bit of the previous word).
   always_ff @(posedge t_clk or negedge r) begin
      if (!r) begin
         y       <= 1'b0;
         y_valid <= 1'b0;
         y_sof   <= 1'b0;
         ovf     <= 1'b0;
         shreg   <= '0;
         rem     <= '0;
         neg_r   <= 1'b0;
         inv_r   <= 1'b0;
         ovf_arm <= 1'b0;
         seen    <= 1'b0;
      end else begin
         y_sof <= 1'b0;
         ovf   <= 1'b0;
         if (load) begin
            y       <= inv_ld ? ~word_full[0] : word_full[0];
            y_valid <= 1'b1;
            y_sof   <= 1'b1;
            shreg   <= {1'b0, word_full[WIDTH-1:1]};
            rem     <= LAST;
            neg_r   <= neg_ld;
            inv_r   <= inv_ld;
            seen    <= word_full[0];
            ovf_arm <= neg_ld && (word_full == MOST_NEG);
         end else if (rem != '0) begin
            y       <= out_bit;
            y_valid <= 1'b1;
            shreg   <= {1'b0, shreg[WIDTH-1:1]};
            seen    <= seen | shreg[0];
            rem     <= rem - ONE;
            if (rem == ONE) begin
               ovf <= ovf_arm;
            end
         end else begin
            y       <= 1'b0;
            y_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_twos_comp_word.sv
module tb_serial_twos_comp_word;

   logic       t_clk = 1'b0;
   logic       r = 1'b0;
   logic       i = 1'b0;
   logic       i_valid = 1'b0;
   logic       i_sof = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       y;
   logic       y_valid;
   logic       y_sof;
   logic       ovf;
   logic       err_frm;

   serial_twos_comp_word #(.WIDTH(8)) dut (
      .t_clk   (t_clk),
      .r       (r),
      .i       (i),
      .i_valid (i_valid),
      .i_sof   (i_sof),
      .mode    (mode),
      .y       (y),
      .y_valid (y_valid),
      .y_sof   (y_sof),
      .ovf     (ovf),
      .err_frm (err_frm)
   );

   always #5 t_clk = ~t_clk;

   int         total = 0;
   int         pass_cnt = 0;
   int         err_seen = 0;
   int         vld_seen = 0;
   int         exp_vld = 0;
   logic [2:0] q[$];          // {bit, sof, ovf} per expected output bit
   logic [2:0] e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference transform on whole words
   function automatic logic [7:0] model(input logic [7:0] w, input logic [1:0] m);
      case (m)
         2'b00:   model = w;
         2'b01:   model = ~w;
         2'b10:   model = ~w + 8'd1;
         default: model = w[7] ? (~w + 8'd1) : w;
      endcase
   endfunction

   task automatic push_word(input logic [7:0] w, input logic [1:0] m);
      logic [7:0] res;
      logic       ov;
      res = model(w, m);
      ov  = (m[1] == 1'b1) && (w == 8'h80);
      for (int k = 0; k < 8; k++) begin
         q.push_back({res[k], (k == 0), (ov && (k == 7))});
      end
      exp_vld += 8;
   endtask

   // Scoreboard: every valid output bit is compared against the queue head
   always @(negedge t_clk) begin
      if (err_frm) err_seen++;
      if (y_valid) begin
         vld_seen++;
         if (q.size() == 0) begin
            check("unexpected_y_valid", 1, 0);
         end else begin
            e = q.pop_front();
            check("y_bit", y, e[2]);
            check("y_sof", y_sof, e[1]);
            check("ovf", ovf, e[0]);
         end
      end
   end

   task automatic drive_bit(input logic b, input logic sof, input logic [1:0] m);
      @(negedge t_clk);
      i       = b;
      i_sof   = sof;
      i_valid = 1'b1;
      mode    = m;
   endtask

   // i_sof is left high during idle cycles: it must be ignored without i_valid
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge t_clk);
         i_valid = 1'b0;
         i_sof   = 1'b1;
         i       = 1'b1;
      end
   endtask

   // mode toggles to a different value until the last bit to show it is sampled only at load
   task automatic send_word(input logic [7:0] w, input logic [1:0] m,
                            input int gap_at, input int gap_len);
      for (int k = 0; k < 8; k++) begin
         if (k == gap_at) idle(gap_len);
         if (k == 7) push_word(w, m);
         drive_bit(w[k], (k == 0), (k == 7) ? m : ~m);
      end
   endtask

   task automatic expect_start(input string tag);
      @(negedge t_clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
      check({tag, "_start_vld"}, y_valid, 1);
      check({tag, "_start_sof"}, y_sof, 1);
   endtask

   int e0;
   int v0;
   int n;

   initial begin
      // reset state
      #12;
      check("rst_y", y, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_y_sof", y_sof, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err_frm", err_frm, 0);
      @(negedge t_clk);
      r = 1'b1;
      idle(2);

      send_word(8'h05, 2'b10, -1, 0); expect_start("neg05"); idle(9);
      send_word(8'hFB, 2'b11, -1, 0); expect_start("absFB"); idle(9);
      send_word(8'h05, 2'b11, -1, 0); expect_start("abs05"); idle(9);
      send_word(8'h3C, 2'b01, -1, 0); expect_start("ones3C"); idle(9);
      send_word(8'hA5, 2'b00, -1, 0); expect_start("passA5"); idle(9);
      send_word(8'h80, 2'b10, -1, 0); expect_start("neg80"); idle(9);
      send_word(8'h00, 2'b10, -1, 0); expect_start("neg00"); idle(9);

      // gap of 3 invalid cycles between bits 2 and 3
      send_word(8'h05, 2'b10, 3, 3); expect_start("gap05"); idle(9);

      // early i_sof at bit 3 aborts the partial word
      e0 = err_seen;
      drive_bit(1'b1, 1'b1, 2'b10);
      drive_bit(1'b1, 1'b0, 2'b10);
      drive_bit(1'b1, 1'b0, 2'b10);
      send_word(8'h01, 2'b10, -1, 0); expect_start("err01"); idle(9);
      check("err_frm_pulses", err_seen - e0, 1);

      // bits without i_sof in HUNT are discarded
      v0 = vld_seen;
      e0 = err_seen;
      for (int k = 0; k < 10; k++) drive_bit(k[0], 1'b0, 2'b10);
      idle(12);
      check("hunt_no_output", vld_seen - v0, 0);
      check("hunt_no_err", err_seen - e0, 0);

      // back-to-back words
      send_word(8'h05, 2'b10, -1, 0);
      send_word(8'h80, 2'b11, -1, 0);
      send_word(8'h7F, 2'b00, -1, 0);
      expect_start("b2b"); idle(9);

      // reset in the middle of an output word
      send_word(8'h3C, 2'b01, -1, 0); expect_start("pre_rst");
      idle(2);
      #2 r = 1'b0;
      #1;
      check("midrst_y", y, 0);
      check("midrst_y_valid", y_valid, 0);
      check("midrst_y_sof", y_sof, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_err_frm", err_frm, 0);
      exp_vld -= q.size();
      q.delete();
      @(negedge t_clk);
      r = 1'b1;
      idle(2);
      send_word(8'h05, 2'b10, -1, 0); expect_start("post_rst");

      // drain with a bounded wait
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge t_clk);
         n++;
      end
      check("drain_empty", q.size(), 0);
      idle(5);
      check("valid_bit_count", vld_seen, exp_vld);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
